// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator request scheduler and state machine.
package elevator_pkg;

  localparam int          NUM_FLOORS  = 6;
  localparam int          FLOOR_W     = 4;
  localparam logic [31:0] DOOR_CYCLES = 32'd5000000;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef logic [FLOOR_W-1:0] floor_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge pulse, one lane per button.
module btn_sync_edge #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] sync_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      sync_p2 <= '0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // Pulse is high for exactly one cycle, however long the button is held.
  assign pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN-order request scheduler feeding requested_floor to the elevator state machine.
// Optional door dwell hold enabled by defining ELEVATOR_DOOR_HOLD_EN.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
`ifdef ELEVATOR_DOOR_HOLD_EN
  ,
  parameter logic [31:0] DOOR_CYCLES = elevator_pkg::DOOR_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  door_open
);

  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] press_pulse;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] pending_nxt;
  logic                  door_active;

  logic                  up_found;
  logic                  dn_found;
  logic [FLOOR_W-1:0]    lo_ge_f;
  logic [FLOOR_W-1:0]    lo_gt_f;
  logic [FLOOR_W-1:0]    hi_le_f;
  logic [FLOOR_W-1:0]    hi_lt_f;
  logic [FLOOR_W-1:0]    target_nxt;
  logic                  dir_nxt;

  btn_sync_edge #(
    .WIDTH (NUM_FLOORS)
  ) u_btn_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .btn   (call_btn),
    .pulse (press_pulse)
  );

  // An out-of-range current_floor matches no lane, so nothing clears.
  always_comb begin
    clear_mask = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      clear_mask[f] = car_idle && !door_active && (current_floor == FLOOR_W'(f));
    end
  end

  // Clear beats a simultaneous press on the same floor.
  assign pending_nxt = (pending | press_pulse) & ~clear_mask;

  always_comb begin
    up_found = 1'b0;
    dn_found = 1'b0;
    lo_ge_f  = '0;
    lo_gt_f  = '0;
    hi_le_f  = '0;
    hi_lt_f  = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pending[f] && (FLOOR_W'(f) >= current_floor)) begin
        up_found = 1'b1;
        lo_ge_f  = FLOOR_W'(f);
      end
      if (pending[f] && (FLOOR_W'(f) > current_floor)) begin
        lo_gt_f = FLOOR_W'(f);
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (FLOOR_W'(f) <= current_floor)) begin
        dn_found = 1'b1;
        hi_le_f  = FLOOR_W'(f);
      end
      if (pending[f] && (FLOOR_W'(f) < current_floor)) begin
        hi_lt_f = FLOOR_W'(f);
      end
    end
  end

  always_comb begin
    target_nxt = current_floor;
    dir_nxt    = dir_up;
    if (door_active || (pending == '0)) begin
      target_nxt = current_floor;
      dir_nxt    = dir_up;
    end else if (dir_up == DIR_UP) begin
      if (up_found) begin
        target_nxt = lo_ge_f;
      end else begin
        target_nxt = hi_lt_f;
        dir_nxt    = DIR_DOWN;
      end
    end else begin
      if (dn_found) begin
        target_nxt = hi_le_f;
      end else begin
        target_nxt = lo_gt_f;
        dir_nxt    = DIR_UP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending         <= '0;
      requested_floor <= '0;
      dir_up          <= DIR_UP;
    end else begin
      pending         <= pending_nxt;
      requested_floor <= target_nxt;
      dir_up          <= dir_nxt;
    end
  end

`ifdef ELEVATOR_DOOR_HOLD_EN
  logic        clear_hit;
  logic        door_q;
  logic [31:0] dwell_cnt;

  // Door only opens when a request at this floor is actually being served.
  assign clear_hit = |(clear_mask & (pending | press_pulse));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      door_q    <= 1'b0;
      dwell_cnt <= '0;
    end else if (door_q) begin
      if (dwell_cnt == 32'd0) begin
        door_q <= 1'b0;
      end else begin
        dwell_cnt <= dwell_cnt - 32'd1;
      end
    end else if (clear_hit) begin
      door_q    <= 1'b1;
      dwell_cnt <= DOOR_CYCLES;
    end
  end

  assign door_active = door_q;
`else
  assign door_active = 1'b0;
`endif

  assign door_open = door_active;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Randomised and directed bench for elevator_request_scheduler against a behavioural SCAN model.
module tb_elevator_request_scheduler;
  import elevator_pkg::*;

  localparam int NF = 6;
  localparam int FW = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] call_btn;
  floor_t        current_floor;
  logic          car_idle;
  logic [FW-1:0] requested_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          door_open;

  always #5 clk = ~clk;

  elevator_request_scheduler #(
    .NUM_FLOORS  (NF),
    .FLOOR_W     (FW)
`ifdef ELEVATOR_DOOR_HOLD_EN
    ,
    .DOOR_CYCLES (32'(DC))
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .call_btn        (call_btn),
    .current_floor   (current_floor),
    .car_idle        (car_idle),
    .requested_floor (requested_floor),
    .pending         (pending),
    .dir_up          (dir_up),
    .door_open       (door_open)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  bit [NF-1:0] m_pend;
  int          m_req;
  bit          m_dir;
  bit          m_door;
  int          m_cnt;
  bit [NF-1:0] m_hist[$];

  task automatic model_reset();
    m_pend = '0;
    m_req  = 0;
    m_dir  = 1'b1;
    m_door = 1'b0;
    m_cnt  = 0;
    m_hist.delete();
    repeat (4) m_hist.push_front('0);
  endtask

  function automatic void sched(input bit [NF-1:0] p, input int cf, input bit dir,
                                output int tgt, output bit nd);
    int lo_ge = -1;
    int lo_gt = -1;
    int hi_le = -1;
    int hi_lt = -1;
    tgt = cf;
    nd  = dir;
    if (p == '0) return;
    for (int f = 0; f < NF; f++) begin
      if (p[f]) begin
        if (f >= cf && lo_ge < 0) lo_ge = f;
        if (f > cf && lo_gt < 0) lo_gt = f;
        if (f <= cf) hi_le = f;
        if (f < cf) hi_lt = f;
      end
    end
    if (dir) begin
      if (lo_ge >= 0) tgt = lo_ge;
      else begin tgt = hi_lt; nd = 1'b0; end
    end else begin
      if (hi_le >= 0) tgt = hi_le;
      else begin tgt = lo_gt; nd = 1'b1; end
    end
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit [NF-1:0] pulse;
    bit [NF-1:0] newp;
    int          cf;
    int          nreq;
    bit          ndir;
    bit          can_clear;
    bit          hit;
    if (rst) begin
      model_reset();
      return;
    end
    m_hist.push_front(call_btn);
    pulse = m_hist[2] & ~m_hist[3];
    void'(m_hist.pop_back());
    cf = int'(current_floor);
    can_clear = car_idle && (cf < NF) && !m_door;
    hit = 1'b0;
    if (can_clear) hit = m_pend[cf] | pulse[cf];
    if (m_door) begin
      nreq = cf;
      ndir = m_dir;
    end else begin
      sched(m_pend, cf, m_dir, nreq, ndir);
    end
    newp = m_pend | pulse;
    if (can_clear) newp[cf] = 1'b0;
`ifdef ELEVATOR_DOOR_HOLD_EN
    if (m_door) begin
      if (m_cnt == 0) m_door = 1'b0;
      else m_cnt--;
    end else if (hit) begin
      m_door = 1'b1;
      m_cnt  = DC;
    end
`else
    if (hit) m_door = 1'b0;
`endif
    m_pend = newp;
    m_req  = nreq;
    m_dir  = ndir;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("pending", 32'(pending), 32'(m_pend));
    check_val("requested_floor", 32'(requested_floor), 32'(m_req));
    check_val("dir_up", 32'(dir_up), 32'(m_dir));
    check_val("door_open", 32'(door_open), 32'(m_door));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    call_btn      = '0;
    current_floor = '0;
    car_idle      = 1'b0;
    model_reset();
    repeat (2) step();
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_req", 32'(requested_floor), 32'd0);
    check_val("rst_dir", 32'(dir_up), 32'd1);
    check_val("rst_door", 32'(door_open), 32'd0);
    rst = 1'b0;

    // Press floor 3 for three cycles with the car at 0
    call_btn = 6'b001000;
    step();
    step();
    step();
    check_val("t1_pending_n2", 32'(pending), 32'b001000);
    call_btn = '0;
    step();
    check_val("t1_req_n3", 32'(requested_floor), 32'd3);
    check_val("t1_dir", 32'(dir_up), 32'd1);
    do_reset();

    // Held button yields one request, then served at floor 2
    call_btn = 6'b000100;
    repeat (100) step();
    call_btn = '0;
    check_val("t2_held_pending", 32'(pending), 32'b000100);
    current_floor = 4'd2;
    car_idle      = 1'b1;
    step();
    check_val("t2_cleared", 32'(pending), 32'd0);
    check_val("t2_req", 32'(requested_floor), 32'd2);
    car_idle = 1'b0;
    do_reset();

    // Up-scan to 4, then reverse to 0
    current_floor = 4'd2;
    call_btn      = 6'b010001;
    step();
    call_btn = '0;
    repeat (4) step();
    check_val("t3_req_up", 32'(requested_floor), 32'd4);
    check_val("t3_dir_up", 32'(dir_up), 32'd1);
    current_floor = 4'd4;
    car_idle      = 1'b1;
    step();
    car_idle = 1'b0;
    repeat (8) step();
    check_val("t3_req_rev", 32'(requested_floor), 32'd0);
    check_val("t3_dir_rev", 32'(dir_up), 32'd0);
    do_reset();

    // Press at the floor where the car idles: clear wins
    current_floor = 4'd1;
    car_idle      = 1'b1;
    call_btn      = 6'b000010;
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("t4_pending1", 32'(pending[1]), 32'd0);
      check_val("t4_req", 32'(requested_floor), 32'd1);
    end
    call_btn = '0;
    car_idle = 1'b0;
    do_reset();

    // Preemption by a closer request, then asynchronous reset mid-travel
    current_floor = 4'd2;
    call_btn      = 6'b100000;
    step();
    call_btn = '0;
    repeat (4) step();
    check_val("t5_req5", 32'(requested_floor), 32'd5);
    call_btn = 6'b001000;
    step();
    call_btn = '0;
    step();
    step();
    check_val("t5_req_n2", 32'(requested_floor), 32'd5);
    step();
    check_val("t5_req_n3", 32'(requested_floor), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_async_pending", 32'(pending), 32'd0);
    check_val("t5_async_req", 32'(requested_floor), 32'd0);
    check_val("t5_async_dir", 32'(dir_up), 32'd1);
    check_val("t5_async_door", 32'(door_open), 32'd0);
    model_reset();
    step();
    rst = 1'b0;

`ifdef ELEVATOR_DOOR_HOLD_EN
    // Dwell at floor 3 with floor 5 still pending
    current_floor = 4'd0;
    call_btn      = 6'b101000;
    step();
    call_btn = '0;
    repeat (4) step();
    check_val("t6_req3", 32'(requested_floor), 32'd3);
    current_floor = 4'd3;
    car_idle      = 1'b1;
    step();
    check_val("t6_door_open", 32'(door_open), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t6_door_held", 32'(door_open), 32'd1);
      check_val("t6_req_held", 32'(requested_floor), 32'd3);
    end
    step();
    check_val("t6_door_closed", 32'(door_open), 32'd0);
    step();
    check_val("t6_req5", 32'(requested_floor), 32'd5);
    car_idle = 1'b0;
    do_reset();
`endif

    // Randomised traffic, including out-of-range floors and occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NF; b++) begin
        if ($urandom_range(0, 7) == 0) call_btn[b] = ~call_btn[b];
      end
      if ($urandom_range(0, 5) == 0) current_floor = floor_t'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) current_floor = 4'd15;
      car_idle = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
